// File: rtl/nukv_fifo_rr_arbiter.sv
// nukv_fifo_rr_arbiter
// Three-input round-robin arbiter feeding one FIFO write port. A grant is held
// for a bounded burst. The selected word is registered into a single output
// slot together with the index of its source.
module nukv_fifo_rr_arbiter #(
  parameter int DATA_SIZE = 16,
  parameter int MAX_BURST = 8
) (
  input  logic                 s_axis_clk,
  input  logic                 s_axis_rst,
  input  logic [DATA_SIZE-1:0] s0_axis_tdata,
  input  logic                 s0_axis_tvalid,
  output logic                 s0_axis_tready,
  input  logic [DATA_SIZE-1:0] s1_axis_tdata,
  input  logic                 s1_axis_tvalid,
  output logic                 s1_axis_tready,
  input  logic [DATA_SIZE-1:0] s2_axis_tdata,
  input  logic                 s2_axis_tvalid,
  output logic                 s2_axis_tready,
  output logic [DATA_SIZE-1:0] m_axis_tdata,
  output logic [1:0]           m_axis_tsrc,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  input  logic                 m_axis_talmostfull
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BURST - 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t         state, state_next;
  logic [1:0]     grant, grant_next;
  logic [1:0]     last, last_next;
  logic [CW-1:0]  cnt, cnt_next;

  logic           slot_free;
  logic           open;
  logic           gvalid;
  logic [DATA_SIZE-1:0] gdata;
  logic           xfer;
  logic [3:0]     valid_vec;
  logic [1:0]     cand [3];
  logic [1:0]     winner;
  logic           found;

  // Successor in the 0 -> 1 -> 2 -> 0 ring.
  function automatic logic [1:0] inc3(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  // The output slot can take a new word if it is empty or draining this cycle.
  assign slot_free = !m_axis_tvalid || m_axis_tready;
  // Acceptance window for the granted input; almost-full blocks it outright.
  assign open = (state == BURST) && slot_free && !m_axis_talmostfull;

  assign s0_axis_tready = open && (grant == 2'd0);
  assign s1_axis_tready = open && (grant == 2'd1);
  assign s2_axis_tready = open && (grant == 2'd2);

  // Route the granted input's valid and data.
  always_comb begin
    gvalid = 1'b0;
    gdata  = '0;
    case (grant)
      2'd0: begin gvalid = s0_axis_tvalid; gdata = s0_axis_tdata; end
      2'd1: begin gvalid = s1_axis_tvalid; gdata = s1_axis_tdata; end
      2'd2: begin gvalid = s2_axis_tvalid; gdata = s2_axis_tdata; end
      default: begin gvalid = 1'b0; gdata = '0; end
    endcase
  end

  assign xfer = open && gvalid;

  // Round-robin search: last+1, last+2, then last itself.
  always_comb begin
    valid_vec = {1'b0, s2_axis_tvalid, s1_axis_tvalid, s0_axis_tvalid};
    cand[0]   = inc3(last);
    cand[1]   = inc3(inc3(last));
    cand[2]   = last;
    found     = 1'b0;
    winner    = 2'd0;
    for (int k = 0; k < 3; k++) begin
      if (!found && valid_vec[cand[k]]) begin
        found  = 1'b1;
        winner = cand[k];
      end
    end
  end

  // Arbitration and burst-tracking next state.
  always_comb begin
    state_next = state;
    grant_next = grant;
    last_next  = last;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (found) begin
          grant_next = winner;
          last_next  = winner;
          cnt_next   = '0;
          state_next = BURST;
        end
      end
      BURST: begin
        if (xfer) begin
          cnt_next = cnt + 1'b1;
          if (cnt == LAST_CNT) begin
            state_next = IDLE;
          end
        end else if (open && !gvalid) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Arbiter state registers.
  always_ff @(posedge s_axis_clk or negedge s_axis_rst) begin
    if (!s_axis_rst) begin
      state <= IDLE;
      grant <= 2'd0;
      last  <= 2'd2;
      cnt   <= '0;
    end else begin
      state <= state_next;
      grant <= grant_next;
      last  <= last_next;
      cnt   <= cnt_next;
    end
  end

  // Output slot: load on transfer, otherwise clear once the word is taken.
  always_ff @(posedge s_axis_clk or negedge s_axis_rst) begin
    if (!s_axis_rst) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tsrc   <= 2'd0;
    end else if (xfer) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= gdata;
      m_axis_tsrc   <= grant;
    end else if (m_axis_tvalid && m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_nukv_fifo_rr_arbiter.sv
// Bench for nukv_fifo_rr_arbiter: directed scenarios plus random traffic,
// every cycle checked against a transaction-level reference model.
module tb_nukv_fifo_rr_arbiter;
  localparam int DW = 16;
  localparam int MB = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic [DW-1:0] d0, d1, d2;
  logic v0, v1, v2;
  logic r0, r1, r2;
  logic [DW-1:0] m_tdata;
  logic [1:0] m_tsrc;
  logic m_tvalid;
  logic m_ready;
  logic afull;

  always #5 clk = ~clk;

  nukv_fifo_rr_arbiter #(.DATA_SIZE(DW), .MAX_BURST(MB)) dut (
    .s_axis_clk(clk), .s_axis_rst(rst_n),
    .s0_axis_tdata(d0), .s0_axis_tvalid(v0), .s0_axis_tready(r0),
    .s1_axis_tdata(d1), .s1_axis_tvalid(v1), .s1_axis_tready(r1),
    .s2_axis_tdata(d2), .s2_axis_tvalid(v2), .s2_axis_tready(r2),
    .m_axis_tdata(m_tdata), .m_axis_tsrc(m_tsrc), .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_ready), .m_axis_talmostfull(afull)
  );

  // Reference model: who owns the port (-1 = nobody), words taken this burst,
  // most recent winner, and the single output word in flight.
  int owner, taken, last_win;
  bit slot_v;
  logic [DW-1:0] slot_d;
  int slot_s;
  int seq [3];

  int vectors = 0;
  int miscompares = 0;
  int n_cmp = 0;

  // Per-cycle observations used by directed scenarios.
  bit acc [3];
  bit rdy_obs [3];
  bit out_hs;
  int out_src;
  int srcq [$];

  function automatic logic [DW-1:0] word_of(input int n);
    return DW'((n << 14) | (seq[n] & 'h3fff));
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    owner = -1; taken = 0; last_win = 2; slot_v = 0; slot_d = '0; slot_s = 0;
  endtask

  // One clock: drive data, compare at the falling edge, advance the model.
  task automatic tick();
    bit vv [3];
    bit er [3];
    logic [DW-1:0] dd [3];
    bit free, accept, was_idle;
    d0 = word_of(0); d1 = word_of(1); d2 = word_of(2);
    vectors++;
    @(negedge clk);
    vv[0] = v0; vv[1] = v1; vv[2] = v2;
    dd[0] = d0; dd[1] = d1; dd[2] = d2;
    rdy_obs[0] = r0; rdy_obs[1] = r1; rdy_obs[2] = r2;
    for (int n = 0; n < 3; n++) acc[n] = rdy_obs[n] && vv[n];
    out_hs = m_tvalid && m_ready;
    out_src = int'(m_tsrc);
    if (out_hs) srcq.push_back(out_src);

    free = !slot_v || m_ready;
    for (int n = 0; n < 3; n++) er[n] = (owner == n) && free && !afull;
    chk("s0_tready", 32'(r0), 32'(er[0]));
    chk("s1_tready", 32'(r1), 32'(er[1]));
    chk("s2_tready", 32'(r2), 32'(er[2]));
    chk("m_tvalid", 32'(m_tvalid), 32'(slot_v));
    if (slot_v) begin
      chk("m_tdata", 32'(m_tdata), 32'(slot_d));
      chk("m_tsrc", 32'(m_tsrc), 32'(slot_s));
    end

    was_idle = (owner < 0);
    accept = !was_idle && er[owner] && vv[owner];
    if (accept) begin
      slot_v = 1; slot_d = dd[owner]; slot_s = owner;
      seq[owner]++;
      taken++;
      if (taken == MB) owner = -1;
    end else begin
      if (slot_v && m_ready) slot_v = 0;
      if (!was_idle) begin
        if (free && !afull && !vv[owner]) owner = -1;
      end else begin
        for (int k = 1; k <= 3; k++) begin
          int c;
          c = (last_win + k) % 3;
          if (owner < 0 && vv[c]) begin
            owner = c; last_win = c; taken = 0;
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Assert reset (asynchronously), check outputs clear at once, release.
  task automatic do_reset();
    rst_n = 1'b0;
    m_ready = 1'b1;
    afull = 1'b0;
    model_reset();
    #1;
    chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_m_tdata", 32'(m_tdata), 32'd0);
    chk("rst_m_tsrc", 32'(m_tsrc), 32'd0);
    chk("rst_treadies", 32'({r2, r1, r0}), 32'd0);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int runs [$];
    int cur, cnt0, base, total, got, n2, cap_s;
    logic [DW-1:0] cap_d;
    rst_n = 1'b1; v0 = 0; v1 = 0; v2 = 0; m_ready = 1; afull = 0;
    d0 = '0; d1 = '0; d2 = '0;
    for (int n = 0; n < 3; n++) seq[n] = 0;
    model_reset();
    #2;

    // s0 alone, 20 words: bursts of 8, 8, 4.
    do_reset();
    base = seq[0]; cur = 0; cnt0 = 0;
    for (int i = 0; i < 40; i++) begin
      v0 = (seq[0] < base + 20);
      tick();
      if (acc[0]) cur++;
      else if (cur > 0) begin runs.push_back(cur); cur = 0; end
      if (out_hs && out_src == 0) cnt0++;
    end
    chk("s0_nbursts", 32'(runs.size()), 32'd3);
    if (runs.size() == 3) begin
      chk("s0_burst0", 32'(runs[0]), 32'd8);
      chk("s0_burst1", 32'(runs[1]), 32'd8);
      chk("s0_burst2", 32'(runs[2]), 32'd4);
    end
    chk("s0_words_out", 32'(cnt0), 32'd20);
    $display("scenario s0-alone: bursts=%0d words_out=%0d", runs.size(), cnt0);

    // All three continuously valid: sources rotate 0,1,2 every 8 words.
    v0 = 0;
    do_reset();
    srcq.delete();
    v0 = 1; v1 = 1; v2 = 1;
    for (int i = 0; i < 60; i++) tick();
    chk("rr_word_count_ge48", 32'(srcq.size() >= 48), 32'd1);
    for (int i = 0; i < 48 && i < srcq.size(); i++)
      chk("rr_tsrc", 32'(srcq[i]), 32'((i / MB) % 3));
    $display("scenario round-robin: %0d words observed", srcq.size());

    // s1 granted, almost-full for 5 cycles after 3 words.
    v0 = 0; v1 = 0; v2 = 0;
    do_reset();
    v1 = 1; total = 0;
    for (int i = 0; i < 20 && total < 3; i++) begin
      tick();
      if (acc[1]) total++;
    end
    afull = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("afull_s1_tready", 32'(rdy_obs[1]), 32'd0);
    end
    afull = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (acc[1]) total++;
      else break;
    end
    chk("afull_burst_len", 32'(total), 32'd8);
    $display("scenario almost-full: burst length %0d", total);

    // Downstream stall for 4 cycles with the slot full.
    v1 = 0;
    do_reset();
    m_ready = 0; v0 = 1;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      tick();
      got = m_tvalid;
    end
    chk("stall_slot_full", 32'(got), 32'd1);
    cap_d = m_tdata; cap_s = int'(m_tsrc);
    total = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall_tvalid", 32'(m_tvalid), 32'd1);
      chk("stall_tdata", 32'(m_tdata), 32'(cap_d));
      chk("stall_tsrc", 32'(m_tsrc), 32'(cap_s));
      if (acc[0]) total++;
    end
    chk("stall_accepts", 32'(total), 32'd0);
    m_ready = 1;
    tick();
    chk("stall_release_hs", 32'(out_hs), 32'd1);
    chk("stall_release_acc", 32'(acc[0]), 32'd1);
    $display("scenario stall: held word %0h src %0d", cap_d, cap_s);

    // s2 stops after 2 words while s0 waits.
    v0 = 0;
    do_reset();
    srcq.delete();
    v2 = 1;
    tick();
    v0 = 1; total = 0;
    for (int i = 0; i < 10 && total < 2; i++) begin
      tick();
      if (acc[2]) total++;
    end
    v2 = 0;
    tick();
    chk("s2_release_acc0", 32'(acc[0]), 32'd0);
    tick();
    chk("s2_idle_acc0", 32'(acc[0]), 32'd0);
    tick();
    chk("s2_then_s0_acc", 32'(acc[0]), 32'd1);
    n2 = 0;
    foreach (srcq[i]) if (srcq[i] == 2) n2++;
    chk("s2_words_out", 32'(n2), 32'd2);
    $display("scenario s2-release: s2 words out %0d", n2);

    // Reset in the middle of a burst with the slot full.
    v0 = 1; v1 = 1; v2 = 1;
    for (int i = 0; i < 4; i++) tick();
    chk("midrst_slot_full", 32'(m_tvalid), 32'd1);
    do_reset();
    tick();
    tick();
    chk("midrst_first_s0", 32'(acc[0]), 32'd1);
    chk("midrst_not_s1", 32'(acc[1] || acc[2]), 32'd0);
    $display("scenario mid-burst reset: first acceptance from s0=%0d", acc[0]);

    // Random traffic.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      v0 = ($urandom_range(0, 9) < 7);
      v1 = ($urandom_range(0, 9) < 6);
      v2 = ($urandom_range(0, 9) < 5);
      m_ready = ($urandom_range(0, 9) < 8);
      afull = ($urandom_range(0, 9) < 2);
      tick();
    end
    $display("random phase done: %0d comparisons so far", n_cmp);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
